// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pkg
// Purpose  : Shared mode encodings and default sizing for the immediate
//            extension pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

   localparam int unsigned c_DEF_IN_W   = 16;
   localparam int unsigned c_DEF_OUT_W  = 32;
   localparam int unsigned c_DEF_SH_LSB = 6;
   localparam int unsigned c_DEF_SH_W   = 5;
   localparam int unsigned c_MODE_W     = 3;

   typedef enum logic [2:0] {
      MODE_ZERO   = 3'd0,
      MODE_SIGN   = 3'd1,
      MODE_SHAMT  = 3'd2,
      MODE_UPPER  = 3'd3,
      MODE_BRANCH = 3'd4
   } mode_e;

   // Encodings above MODE_BRANCH are reserved and treated as illegal.
   function automatic logic mode_is_legal(input logic [2:0] m);
      return (m <= MODE_BRANCH);
   endfunction

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_ext_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pipe_if
// Purpose  : Valid/ready input and output channels plus sticky-error status
//            of the immediate extension pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface imm_ext_pipe_if
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W  = c_DEF_IN_W,
   parameter int unsigned OUT_W = c_DEF_OUT_W
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [IN_W-1:0]       in_data;
   logic [c_MODE_W-1:0]   in_mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [OUT_W-1:0]      out_data;
   logic                  out_mode_err;
   logic                  err_sticky;
   logic                  err_clr;

   // Producer/consumer side (drives words in, takes results out)
   modport master (
      output in_valid, in_data, in_mode, out_ready, err_clr,
      input  in_ready, out_valid, out_data, out_mode_err, err_sticky
   );

   // Pipeline side
   modport slave (
      input  in_valid, in_data, in_mode, out_ready, err_clr,
      output in_ready, out_valid, out_data, out_mode_err, err_sticky
   );

endinterface : imm_ext_pipe_if
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_core
// Purpose  : Combinational immediate extension: raw field + mode -> extended
//            value and illegal-mode flag.
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W   = c_DEF_IN_W,
   parameter int unsigned OUT_W  = c_DEF_OUT_W,
   parameter int unsigned SH_LSB = c_DEF_SH_LSB,
   parameter int unsigned SH_W   = c_DEF_SH_W
) (
   input  wire logic [IN_W-1:0]     i_data,
   input  wire logic [c_MODE_W-1:0] i_mode,
   output logic      [OUT_W-1:0]    o_value,
   output logic                     o_err
);

   // Reject parameter sets whose extension fields would not fit.
   if (OUT_W < IN_W + 2) begin : g_chk_out_w
      $error("imm_ext_core: OUT_W must be at least IN_W+2");
   end
   if (SH_LSB + SH_W > IN_W) begin : g_chk_sh
      $error("imm_ext_core: shift field exceeds IN_W");
   end

   logic [OUT_W-1:0] w_zext;
   logic [OUT_W-1:0] w_sext;
   logic [OUT_W-1:0] w_shamt;
   logic [OUT_W-1:0] w_upper;
   logic [OUT_W-1:0] w_branch;

   assign w_zext   = {{(OUT_W-IN_W){1'b0}}, i_data};
   assign w_sext   = {{(OUT_W-IN_W){i_data[IN_W-1]}}, i_data};
   assign w_shamt  = {{(OUT_W-SH_W){1'b0}}, i_data[SH_LSB+SH_W-1:SH_LSB]};
   assign w_upper  = {i_data, {(OUT_W-IN_W){1'b0}}};
   // Branch offsets are word-scaled; the top two sign bits fall off.
   assign w_branch = {w_sext[OUT_W-3:0], 2'b00};

   // Select the extension for the requested mode; illegal modes yield zero.
   always_comb begin
      o_value = '0;
      o_err   = !mode_is_legal(i_mode);
      case (i_mode)
         MODE_ZERO:   o_value = w_zext;
         MODE_SIGN:   o_value = w_sext;
         MODE_SHAMT:  o_value = w_shamt;
         MODE_UPPER:  o_value = w_upper;
         MODE_BRANCH: o_value = w_branch;
         default:     o_value = '0;
      endcase
   end

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pipe
// Purpose  : Two-entry (output + skid) valid/ready pipeline that extends an
//            immediate at capture time and holds the registered result.
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W   = c_DEF_IN_W,
   parameter int unsigned OUT_W  = c_DEF_OUT_W,
   parameter int unsigned SH_LSB = c_DEF_SH_LSB,
   parameter int unsigned SH_W   = c_DEF_SH_W
) (
   input  wire logic     clk,
   input  wire logic     reset,
   imm_ext_pipe_if.slave bus
);

   logic [OUT_W-1:0] w_value;
   logic             w_err;
   logic             w_accept;
   logic             w_load_out;

   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_data;
   logic             r_out_err;
   logic             r_skid_valid;
   logic [OUT_W-1:0] r_skid_data;
   logic             r_skid_err;
   logic             r_err_sticky;

   // Extension happens on the raw input so only finished results are stored.
   imm_ext_core #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .SH_LSB (SH_LSB),
      .SH_W   (SH_W)
   ) u_core (
      .i_data  (bus.in_data),
      .i_mode  (bus.in_mode),
      .o_value (w_value),
      .o_err   (w_err)
   );

   // Ready only looks at the skid flop, so it never combinationally
   // depends on downstream ready.
   assign bus.in_ready = !r_skid_valid;
   assign w_accept     = bus.in_valid && !r_skid_valid;
   // Output register may take a new word when empty or being drained.
   assign w_load_out   = !r_out_valid || bus.out_ready;

   // Output/skid data path: skid always drains first to keep ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_err    <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_err   <= 1'b0;
      end else if (w_load_out) begin
         if (r_skid_valid) begin
            // in_ready is low here, so no new word competes with the skid.
            r_out_valid  <= 1'b1;
            r_out_data   <= r_skid_data;
            r_out_err    <= r_skid_err;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_value;
            r_out_err   <= w_err;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_accept) begin
         // Output stalled and full: park the word in the skid register.
         r_skid_valid <= 1'b1;
         r_skid_data  <= w_value;
         r_skid_err   <= w_err;
      end
   end

   // Sticky illegal-mode flag; a new illegal accept beats a clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_sticky <= 1'b0;
      end else if (w_accept && w_err) begin
         r_err_sticky <= 1'b1;
      end else if (bus.err_clr) begin
         r_err_sticky <= 1'b0;
      end
   end

   assign bus.out_valid    = r_out_valid;
   assign bus.out_data     = r_out_data;
   assign bus.out_mode_err = r_out_err;
   assign bus.err_sticky   = r_err_sticky;

endmodule : imm_ext_pipe
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_ext_pipe
// Purpose  : Self-checking bench for imm_ext_pipe (default 16 -> 32 sizing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;
   import imm_ext_pkg::*;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;

   typedef struct {
      logic [2:0]  m;
      logic [15:0] d;
      logic [31:0] ed;
      logic        ee;
   } vec_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   int   n_out;
   exp_t sb[$];
   vec_t vt[10];

   imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

   imm_ext_pipe #(
      .IN_W   (16),
      .OUT_W  (32),
      .SH_LSB (6),
      .SH_W   (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference extension written with integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] m, input logic [15:0] d,
                                         output logic e);
      int s;
      s = int'($signed(d));
      e = 1'b0;
      case (m)
         3'd0:    return {16'h0000, d};
         3'd1:    return 32'(s);
         3'd2:    return 32'((d >> 6) & 16'h001F);
         3'd3:    return {d, 16'h0000};
         3'd4:    return 32'(s * 4);
         default: begin e = 1'b1; return 32'h0; end
      endcase
   endfunction

   // Output monitor: every presented result is checked against the queue
   // head; it is popped only when the downstream takes it.
   always @(negedge clk) begin
      if (!reset && bus.out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
         end else begin
            chk("out_data", bus.out_data, sb[0].d);
            chk("out_mode_err", 32'(bus.out_mode_err), 32'(sb[0].e));
            if (bus.out_ready) begin
               void'(sb.pop_front());
               n_out++;
            end
         end
      end
   end

   // Offer one word (called at posedge+1); returns at posedge+1 after accept.
   task automatic send(input logic [2:0] m, input logic [15:0] d,
                       input logic [31:0] ed, input logic ee, output int waits);
      bit done;
      done  = 1'b0;
      waits = 0;
      bus.in_valid = 1'b1;
      bus.in_mode  = m;
      bus.in_data  = d;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back('{d: ed, e: ee});
            done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain_wait();
      for (int k = 0; k < 50 && sb.size() != 0; k++) begin
         @(posedge clk);
      end
      #1;
      chk("queue_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int          w;
      int          n0;
      logic        e;
      logic [31:0] v;
      logic [2:0]  rm;
      logic [15:0] rd;

      n_cmp = 0;
      n_bad = 0;
      n_out = 0;
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = '0;
      bus.out_ready = 1'b1;
      bus.err_clr   = 1'b0;

      vt[0] = '{m: 3'd1, d: 16'h8004, ed: 32'hFFFF8004, ee: 1'b0};
      vt[1] = '{m: 3'd0, d: 16'h8004, ed: 32'h00008004, ee: 1'b0};
      vt[2] = '{m: 3'd2, d: 16'h07C0, ed: 32'h0000001F, ee: 1'b0};
      vt[3] = '{m: 3'd3, d: 16'h1234, ed: 32'h12340000, ee: 1'b0};
      vt[4] = '{m: 3'd4, d: 16'hFFFF, ed: 32'hFFFFFFFC, ee: 1'b0};
      vt[5] = '{m: 3'd1, d: 16'h7FFF, ed: 32'h00007FFF, ee: 1'b0};
      vt[6] = '{m: 3'd4, d: 16'h0001, ed: 32'h00000004, ee: 1'b0};
      vt[7] = '{m: 3'd2, d: 16'hF83F, ed: 32'h00000000, ee: 1'b0};
      vt[8] = '{m: 3'd7, d: 16'h1234, ed: 32'h00000000, ee: 1'b1};
      vt[9] = '{m: 3'd0, d: 16'hFFFF, ed: 32'h0000FFFF, ee: 1'b0};

      // Reset state while reset is held
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_out_mode_err", 32'(bus.out_mode_err), 32'd0);
      chk("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
      reset = 1'b0;

      // Table vectors back-to-back with out_ready high
      for (int i = 0; i < 10; i++) begin
         send(vt[i].m, vt[i].d, vt[i].ed, vt[i].ee, w);
         chk("no_bubble_accept", 32'(w), 32'd0);
         chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
      end
      drain_wait();
      bus.err_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.err_clr = 1'b0;

      // Stall: A, B accepted, C held until out_ready returns
      bus.out_ready = 1'b0;
      send(3'd0, 16'h1111, 32'h00001111, 1'b0, w);
      send(3'd1, 16'h9000, 32'hFFFF9000, 1'b0, w);
      chk("in_ready_after_B", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_mode  = 3'd3;
      bus.in_data  = 16'h00AB;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      fork
         send(3'd3, 16'h00AB, 32'h00AB0000, 1'b0, w);
         begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("consecutive_out_valid", 32'(bus.out_valid), 32'd1);
            end
         end
      join
      drain_wait();

      // Illegal mode and sticky flag
      send(3'd5, 16'hABCD, 32'h0, 1'b1, w);
      chk("sticky_set", 32'(bus.err_sticky), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("sticky_hold", 32'(bus.err_sticky), 32'd1);
      bus.err_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.err_clr = 1'b0;
      chk("sticky_cleared", 32'(bus.err_sticky), 32'd0);
      bus.err_clr = 1'b1;
      send(3'd6, 16'h1234, 32'h0, 1'b1, w);
      bus.err_clr = 1'b0;
      chk("sticky_set_wins", 32'(bus.err_sticky), 32'd1);
      drain_wait();

      // Backpressure-randomised stream against the reference model
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               rm = 3'($urandom_range(0, 7));
               rd = 16'($urandom);
               v  = model(rm, rd, e);
               send(rm, rd, v, e, w);
            end
         end
         begin
            for (int k = 0; k < 40; k++) begin
               @(posedge clk);
               #1;
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.out_ready = 1'b1;
      drain_wait();

      // Reset between edges with both registers full
      bus.out_ready = 1'b0;
      send(3'd0, 16'h0AAA, 32'h00000AAA, 1'b0, w);
      send(3'd5, 16'h0BBB, 32'h00000000, 1'b1, w);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_out_data", bus.out_data, 32'd0);
      chk("midrst_out_mode_err", 32'(bus.out_mode_err), 32'd0);
      chk("midrst_err_sticky", 32'(bus.err_sticky), 32'd0);
      sb.delete();
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      n0 = n_out;
      send(3'd4, 16'h0010, 32'h00000040, 1'b0, w);
      drain_wait();
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset_single_out", 32'(n_out - n0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_imm_ext_pipe
`default_nettype wire
